lfsr_avg_noise: RTL and testbench
=================================

LFSR_AVG_NOISE -- requirements
Module: lfsr_avg_noise

Interface
REQ-001 Parameter WIDTH, 32, LFSR and output width; legal values 8, 16, 24, 32.
REQ-002 Parameter AVG_LOG2, 2, log2 of moving-average depth N = 2^AVG_LOG2; legal range 0..4.
REQ-003 Parameter DEFAULT_SEED, 32'hFFFF_0FFF, seed used at reset and on zero recovery; WIDTH LSBs used.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 enable  in  1  advance LFSR one step this cycle.
REQ-008 seed_load  in  1  load seed and flush averager this cycle.
REQ-009 seed  in  WIDTH  seed value, sampled when seed_load=1.
REQ-010 filt_en  in  1  1 = averaged output, 0 = raw LFSR output; sampled per step.
REQ-011 out_data  out  WIDTH  signed noise sample.
REQ-012 out_valid  out  1  one-cycle pulse, out_data updated this cycle.
REQ-013 lockup  out  1  one-cycle pulse, zero-state recovery occurred.

Function
REQ-014 Galois-free Fibonacci LFSR: shift left, XOR feedback of taps into bit 0; taps (1-based) 8:{8,6,5,4}, 16:{16,15,13,4}, 24:{24,23,22,17}, 32:{32,22,2,1}.
REQ-015 Priority per cycle: seed_load > zero recovery > enable > hold.
REQ-016 seed_load: state <= seed, or DEFAULT_SEED if seed==0; history, sum and fill counter cleared; out_valid=0 next cycle.
REQ-017 Zero state with seed_load=0: state <= DEFAULT_SEED, history/sum/fill cleared, lockup pulses next cycle; enable ignored that cycle.
REQ-018 Enabled step: new state registered; new state pushed into N-deep history; oldest entry dropped.
REQ-019 Running sum, signed, WIDTH+AVG_LOG2 bits: sum <= sum + new - oldest (oldest treated as 0 while filling); never overflows.
REQ-020 Averaged sample = sum_next arithmetic-shifted right by AVG_LOG2 (truncation toward minus infinity).
REQ-021 Fill counter saturates at N; counts enabled steps since reset/flush.
REQ-022 Latency: out_data and out_valid appear the cycle after the enabled step edge (registered outputs).
REQ-023 filt_en=0: out_data = new state, out_valid pulses every step.
REQ-024 filt_en=1: out_data = averaged sample, out_valid pulses only when fill counter has reached N including this step.
REQ-025 History and sum update on every step regardless of filt_en; mode switching needs no refill.
REQ-026 enable=0: all state, out_data held; out_valid=0.
REQ-027 AVG_LOG2=0: averaged output equals raw output, valid from first step.

Reset
REQ-028 Reset: state=DEFAULT_SEED[WIDTH-1:0], history=0, sum=0, fill=0, out_data=0, out_valid=0, lockup=0.
REQ-029 Reset asserted mid-operation takes effect immediately, independent of clk; first step allowed on first edge after deassertion.

Structure
REQ-030 Package lfsr_pkg holds tap-mask table/function per WIDTH, DEFAULT_SEED constant, legal-parameter checks.
REQ-031 Sub-module lfsr_core (state register, feedback, zero detect, seed mux); averager and output stage in top.
REQ-032 Illegal WIDTH or AVG_LOG2 fails elaboration.

Verification
REQ-033 WIDTH=8, seed_load seed=8'h01, filt_en=0, 4 steps -> out_data 8'h02, 8'h04, 8'h08, 8'h11, out_valid each step.
REQ-034 WIDTH=8, AVG_LOG2=2, seed 8'h01, filt_en=1, 4 steps -> out_valid only after step 4, out_data=8'h07 (31>>>2).
REQ-035 WIDTH=8, seed 8'h01, 255 steps -> state returns to 8'h01, no earlier repeat, lockup never pulses.
REQ-036 seed_load with seed=0 -> state=DEFAULT_SEED LSBs; bench forces state 0 -> lockup pulse, state=DEFAULT_SEED, history cleared.
REQ-037 seed_load and enable same cycle -> seed loaded, no step, out_valid=0; reset asserted mid-fill -> all outputs 0 asynchronously.
REQ-038 Toggle filt_en after fill with WIDTH=32 -> averaged output correct on first step after switch, matches reference model.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, per-width tap masks and parameter legality checks
// for the lfsr_avg_noise noise generator.
package lfsr_pkg;

  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hFFFF_0FFF;

  // Bit i set means 1-based tap i+1 feeds the XOR into bit 0.
  function automatic logic [31:0] tap_mask(input int width);
    logic [31:0] mask;
    case (width)
      32'sd8:  mask = 32'h0000_00B8;
      32'sd16: mask = 32'h0000_D008;
      32'sd24: mask = 32'h00E1_0000;
      32'sd32: mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  function automatic bit width_legal(input int width);
    return (width == 32'sd8) || (width == 32'sd16) ||
           (width == 32'sd24) || (width == 32'sd32);
  endfunction

  function automatic bit avg_log2_legal(input int avg_log2);
    return (avg_log2 >= 32'sd0) && (avg_log2 <= 32'sd4);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR state register with seed mux and zero-state recovery.
// Reports to the parent which action (step or recovery) happens this cycle.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] next_state,
  output logic             step,
  output logic             recover
);

  localparam logic [31:0]      TAP_MASK = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_DEF = DEFAULT_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] load_value_s;
  logic             zero_s;

  // Feedback, zero-seed substitution and per-cycle action decode
  always_comb begin
    next_state = {state_r[WIDTH-2:0], ^(state_r & TAPS)};
    zero_s     = (state_r == ZERO);
    if (seed == ZERO) begin
      load_value_s = SEED_DEF;
    end else begin
      load_value_s = seed;
    end
    recover = zero_s & ~seed_load;
    step    = enable & ~seed_load & ~zero_s;
  end

  // State register: seed load beats zero recovery beats stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SEED_DEF;
    end else if (seed_load) begin
      state_r <= load_value_s;
    end else if (zero_s) begin
      state_r <= SEED_DEF;
    end else if (enable) begin
      state_r <= next_state;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/lfsr_avg_noise.sv
// lfsr_avg_noise: LFSR noise source with an optional 2^AVG_LOG2-deep moving
// average; raw or averaged samples leave through registered outputs.
module lfsr_avg_noise
  import lfsr_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          AVG_LOG2     = 2,
  parameter logic [31:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             filt_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             lockup
);

  localparam int                DEPTH     = 1 << AVG_LOG2;
  localparam int                SUM_W     = WIDTH + AVG_LOG2;
  localparam int                FILL_W    = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(32'd1);

  generate
    if (!width_legal(WIDTH) || !avg_log2_legal(AVG_LOG2)) begin : g_bad_params
      $error("lfsr_avg_noise: illegal WIDTH or AVG_LOG2");
    end
  endgenerate

  logic [WIDTH-1:0]        next_state_s;
  logic                    step_s;
  logic                    recover_s;
  logic [WIDTH-1:0]        hist_r [DEPTH];
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] sum_next_s;
  logic signed [SUM_W-1:0] new_ext_s;
  logic signed [SUM_W-1:0] old_ext_s;
  logic [FILL_W-1:0]       fill_r;
  logic [FILL_W-1:0]       fill_next_s;
  logic [WIDTH-1:0]        avg_s;
  logic                    avg_ready_s;
  logic [WIDTH-1:0]        out_data_r;
  logic                    out_valid_r;
  logic                    lockup_r;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed       (seed),
    .next_state (next_state_s),
    .step       (step_s),
    .recover    (recover_s)
  );

  // Running-sum update; the oldest slot only leaves the sum once the window is full
  always_comb begin
    new_ext_s = SUM_W'($signed(next_state_s));
    if (fill_r == FILL_FULL) begin
      old_ext_s   = SUM_W'($signed(hist_r[DEPTH-1]));
      fill_next_s = fill_r;
    end else begin
      old_ext_s   = {SUM_W{1'b0}};
      fill_next_s = fill_r + FILL_ONE;
    end
    sum_next_s  = sum_r + new_ext_s - old_ext_s;
    avg_s       = WIDTH'(sum_next_s >>> AVG_LOG2);
    avg_ready_s = (fill_next_s == FILL_FULL);
  end

  // Averager history, sum, fill count and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {WIDTH{1'b0}};
      end
      sum_r       <= {SUM_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
    end else if (seed_load || recover_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {WIDTH{1'b0}};
      end
      sum_r       <= {SUM_W{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      lockup_r    <= recover_s;
    end else if (step_s) begin
      hist_r[0] <= next_state_s;
      for (int i = 1; i < DEPTH; i++) begin
        hist_r[i] <= hist_r[i-1];
      end
      sum_r       <= sum_next_s;
      fill_r      <= fill_next_s;
      out_data_r  <= filt_en ? avg_s : next_state_s;
      out_valid_r <= filt_en ? avg_ready_s : 1'b1;
      lockup_r    <= 1'b0;
    end else begin
      sum_r       <= sum_r;
      fill_r      <= fill_r;
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign lockup    = lockup_r;

endmodule

// File: tb/tb_lfsr_avg_noise.sv
// tb_lfsr_avg_noise: three lfsr_avg_noise configurations driven in lockstep and
// checked every cycle against a window-average reference model.
module tb_lfsr_avg_noise;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [31:0] seed;
  logic        filt_en;

  logic [7:0]  d8;
  logic [31:0] d32;
  logic [15:0] d16;
  logic        v8, v32, v16;
  logic        l8, l32, l16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_avg_noise #(.WIDTH(8), .AVG_LOG2(2)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed(seed[7:0]), .filt_en(filt_en), .out_data(d8), .out_valid(v8), .lockup(l8));

  lfsr_avg_noise #(.WIDTH(32), .AVG_LOG2(2)) dut32 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed(seed), .filt_en(filt_en), .out_data(d32), .out_valid(v32), .lockup(l32));

  lfsr_avg_noise #(.WIDTH(16), .AVG_LOG2(0)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed(seed[15:0]), .filt_en(filt_en), .out_data(d16), .out_valid(v16), .lockup(l16));

  // Reference model state, one slot per DUT (0: W8/N4, 1: W32/N4, 2: W16/N1)
  localparam logic [31:0] DEF_SEED = 32'hFFFF_0FFF;
  int          m_w [3] = '{8, 32, 16};
  int          m_l [3] = '{2, 2, 0};
  logic [31:0] m_st [3];
  longint      m_hist [3][16];
  int          m_cnt [3];
  logic [31:0] e_data [3];
  logic        e_valid [3];
  logic        e_lock [3];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] st, input int w);
    int   taps [4];
    logic fb;
    case (w)
      8:       taps = '{8, 6, 5, 4};
      16:      taps = '{16, 15, 13, 4};
      24:      taps = '{24, 23, 22, 17};
      default: taps = '{32, 22, 2, 1};
    endcase
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb ^= st[taps[i]-1];
    return ((st << 1) | {31'b0, fb}) & wmask(w);
  endfunction

  function automatic longint to_signed(input logic [31:0] v, input int w);
    longint r;
    r = longint'(v);
    if (v[w-1]) r = r - (64'sd1 <<< w);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k]    = DEF_SEED & wmask(m_w[k]);
      m_cnt[k]   = 0;
      for (int i = 0; i < 16; i++) m_hist[k][i] = 0;
      e_data[k]  = 32'h0;
      e_valid[k] = 1'b0;
      e_lock[k]  = 1'b0;
    end
  endtask

  task automatic model_cycle();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] mask;
      int          depth;
      longint      sum;
      mask  = wmask(m_w[k]);
      depth = 1 << m_l[k];
      if (seed_load) begin
        m_st[k] = seed & mask;
        if (m_st[k] == 32'h0) m_st[k] = DEF_SEED & mask;
        m_cnt[k]   = 0;
        e_valid[k] = 1'b0;
        e_lock[k]  = 1'b0;
      end else if (m_st[k] == 32'h0) begin
        m_st[k]    = DEF_SEED & mask;
        m_cnt[k]   = 0;
        e_valid[k] = 1'b0;
        e_lock[k]  = 1'b1;
      end else if (enable) begin
        m_st[k] = lfsr_next(m_st[k], m_w[k]);
        for (int i = 15; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = to_signed(m_st[k], m_w[k]);
        if (m_cnt[k] < 16) m_cnt[k]++;
        if (filt_en) begin
          sum = 0;
          for (int i = 0; i < depth && i < m_cnt[k]; i++) sum += m_hist[k][i];
          e_data[k]  = 32'(sum >>> m_l[k]) & mask;
          e_valid[k] = (m_cnt[k] >= depth);
        end else begin
          e_data[k]  = m_st[k];
          e_valid[k] = 1'b1;
        end
        e_lock[k] = 1'b0;
      end else begin
        e_valid[k] = 1'b0;
        e_lock[k]  = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] dut_data(input int k);
    case (k)
      0:       return {24'h0, d8};
      1:       return d32;
      default: return {16'h0, d16};
    endcase
  endfunction

  function automatic logic dut_valid(input int k);
    case (k)
      0:       return v8;
      1:       return v32;
      default: return v16;
    endcase
  endfunction

  function automatic logic dut_lock(input int k);
    case (k)
      0:       return l8;
      1:       return l32;
      default: return l16;
    endcase
  endfunction

  task automatic compare_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("%s_data%0d", tag, k), dut_data(k), e_data[k]);
      check_value($sformatf("%s_valid%0d", tag, k), {31'h0, dut_valid(k)}, {31'h0, e_valid[k]});
      check_value($sformatf("%s_lockup%0d", tag, k), {31'h0, dut_lock(k)}, {31'h0, e_lock[k]});
    end
  endtask

  // Drive happens at the negedge before this call; sample 1ns after the edge
  task automatic do_cycle();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all("cyc");
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] seen;
    int           repeats;
    int           locks;
    logic [7:0]   raw8 [4];

    raw8 = '{8'h02, 8'h04, 8'h08, 8'h11};
    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = 32'h0; filt_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 1'b0;

    // Raw output from seed 1
    seed_load = 1'b1; seed = 32'h1; do_cycle();
    seed_load = 1'b0; enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_cycle();
      check_value("raw8", {24'h0, d8}, {24'h0, raw8[s]});
      check_value("raw8_valid", {31'h0, v8}, 32'h1);
    end

    // Averaged output from seed 1: valid only on the fourth step, 31>>>2
    seed_load = 1'b1; enable = 1'b0; filt_en = 1'b1; do_cycle();
    seed_load = 1'b0; enable = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      do_cycle();
      check_value("avg8_valid", {31'h0, v8}, (s == 4) ? 32'h1 : 32'h0);
    end
    check_value("avg8_data", {24'h0, d8}, 32'h7);

    // Seed load together with enable: load wins, no step
    seed_load = 1'b1; seed = 32'h0000_00A5; enable = 1'b1; do_cycle();
    check_value("load_vs_step", {31'h0, v8}, 32'h0);

    // Zero seed falls back to the default; next raw step from 8'hFF is 8'hFE
    seed_load = 1'b1; seed = 32'h0; do_cycle();
    seed_load = 1'b0; filt_en = 1'b0; do_cycle();
    check_value("zero_seed_step", {24'h0, d8}, 32'hFE);

    // Forced zero state: recovery pulse, default reload, history cleared
    force dut8.u_core.state_r = 8'h00;
    #1;
    release dut8.u_core.state_r;
    m_st[0] = 32'h0;
    do_cycle();
    check_value("lockup_pulse", {31'h0, l8}, 32'h1);
    check_value("lockup_valid", {31'h0, v8}, 32'h0);
    enable = 1'b0; do_cycle();
    check_value("lockup_clear", {31'h0, l8}, 32'h0);
    enable = 1'b1; filt_en = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      do_cycle();
      check_value("refill_valid", {31'h0, v8}, (s == 4) ? 32'h1 : 32'h0);
    end

    // Switch to averaging after the window filled in raw mode
    seed_load = 1'b1; seed = 32'h1234_5678; filt_en = 1'b0; do_cycle();
    seed_load = 1'b0;
    repeat (6) do_cycle();
    filt_en = 1'b1; do_cycle();
    check_value("switch_valid32", {31'h0, v32}, 32'h1);

    // Full 8-bit period from seed 1
    seed_load = 1'b1; seed = 32'h1; filt_en = 1'b0; do_cycle();
    seed_load = 1'b0;
    seen = '0; seen[1] = 1'b1; repeats = 0; locks = 0;
    for (int s = 1; s <= 255; s++) begin
      do_cycle();
      if (l8) locks++;
      if (s < 255) begin
        if (seen[d8]) repeats++;
        seen[d8] = 1'b1;
      end
    end
    check_value("period_repeats", 32'(repeats), 32'h0);
    check_value("period_return", {24'h0, d8}, 32'h1);
    check_value("period_lockups", 32'(locks), 32'h0);

    // Reset mid-fill acts without a clock edge
    seed_load = 1'b1; seed = 32'h0000_5A5A; do_cycle();
    seed_load = 1'b0; filt_en = 1'b1; do_cycle();
    filt_en = 1'b0; do_cycle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_value("async_rst_data", {24'h0, d8}, 32'h0);
    check_value("async_rst_valid", {31'h0, v8}, 32'h0);
    compare_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    do_cycle();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      seed_load = ($urandom_range(39, 0) == 0);
      seed      = ($urandom_range(7, 0) == 0) ? 32'h0 : $urandom();
      enable    = ($urandom_range(9, 0) < 7);
      if ($urandom_range(15, 0) == 0) filt_en = ~filt_en;
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
